// File: rtl/spart_rx_if.sv
// ----------------------------------------------------------------------------
// spart_rx_if
// Bundles the SPART receiver's control inputs and bus-facing outputs.
//   enable      : block enable from the SPART top
//   rx_baud_en  : x OVERSAMPLE receive baud pulse from the baud generator
//   rxd         : asynchronous serial line, idle high
//   rd          : one-clock bus read strobe
//   rx_data     : last received byte
//   rda         : receive data available
//   framing_err : sticky, stop bit sampled low
//   overrun_err : sticky, byte overwritten before it was read
// Modports:
//   master : the SPART top / bus side that drives the line, enables and rd
//   slave  : the receiver itself
// ----------------------------------------------------------------------------
interface spart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 enable;
    logic                 rx_baud_en;
    logic                 rxd;
    logic                 rd;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rda;
    logic                 framing_err;
    logic                 overrun_err;

    modport master (
        output enable, rx_baud_en, rxd, rd,
        input  rx_data, rda, framing_err, overrun_err
    );

    modport slave (
        input  enable, rx_baud_en, rxd, rd,
        output rx_data, rda, framing_err, overrun_err
    );
endinterface

// File: rtl/spart_rx.sv
// ----------------------------------------------------------------------------
// spart_rx
// SPART serial receiver. Synchronises rxd, qualifies the start bit at
// mid-bit, samples each data bit at mid-bit (LSB first), then samples the
// stop bit and loads the assembled byte into the receive data register.
// Frame: 1 start, DATA_BITS data, no parity, 1 stop.
//
// Ports:
//   clk  : system clock, all logic on posedge
//   rst  : synchronous, active-high reset
//   bus  : spart_rx_if.slave
//            in : enable, rx_baud_en, rxd, rd
//            out: rx_data, rda, framing_err, overrun_err
//
// Parameters:
//   DATA_BITS   : data bits per frame (>= 2)
//   OVERSAMPLE  : rx_baud_en ticks per bit period (even, >= 4)
//   SYNC_STAGES : flops in the rxd synchroniser (>= 2)
//
// Build option:
//   SPART_RX_MAJORITY_EN : when defined, every start/data/stop sample is the
//   2-of-3 majority of the synchronised line at target-1, target and
//   target+1 ticks; the decision is taken on the target+1 tick, so all
//   frame timing moves one tick later. When undefined a single sample is
//   taken on the target tick and no majority registers exist.
// ----------------------------------------------------------------------------
module spart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      rst,
    spart_rx_if.slave bus
);

    localparam int HALF = OVERSAMPLE / 2;

`ifdef SPART_RX_MAJORITY_EN
    localparam int DEC_OFS = 1;
`else
    localparam int DEC_OFS = 0;
`endif

    // Tick count on which a decision is taken in START and in DATA/STOP.
    localparam int START_DEC = HALF - 1 + DEC_OFS;
    localparam int BIT_DEC   = OVERSAMPLE - 1 + DEC_OFS;

    localparam int TICK_W = $clog2(OVERSAMPLE + 1);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] START_LAST = TICK_W'(START_DEC);
    localparam logic [TICK_W-1:0] BIT_LAST   = TICK_W'(BIT_DEC);
    // After a decision the counter restarts at DEC_OFS so that the bit
    // period stays OVERSAMPLE ticks even with the delayed majority decision.
    localparam logic [TICK_W-1:0] RELOAD     = TICK_W'(DEC_OFS);
    localparam logic [BIT_W-1:0]  LAST_BIT   = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_armed;
    logic [TICK_W-1:0]      r_tick_cnt;
    logic [BIT_W-1:0]       r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_rx_data;
    logic                   r_rda;
    logic                   r_framing_err;
    logic                   r_overrun_err;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic                   w_tick;
    logic                   w_rxd_s;
    logic                   w_sample;
    state_t                 w_state_nxt;
    logic [TICK_W-1:0]      w_tick_cnt_nxt;
    logic [BIT_W-1:0]       w_bit_cnt_nxt;
    logic                   w_armed_nxt;
    logic                   w_shift_en;
    logic                   w_load;

    assign w_tick  = bus.enable & bus.rx_baud_en;
    assign w_rxd_s = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // rxd synchroniser. Resets to the idle level so a reset never looks like
    // a start bit. Runs regardless of enable.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.rxd};
        end
    end

    // ------------------------------------------------------------------------
    // Bit sampler
    // ------------------------------------------------------------------------
`ifdef SPART_RX_MAJORITY_EN
    localparam logic [TICK_W-1:0] START_WIN_A = TICK_W'(START_DEC - 2);
    localparam logic [TICK_W-1:0] START_WIN_B = TICK_W'(START_DEC - 1);
    localparam logic [TICK_W-1:0] BIT_WIN_A   = TICK_W'(BIT_DEC - 2);
    localparam logic [TICK_W-1:0] BIT_WIN_B   = TICK_W'(BIT_DEC - 1);

    // The two earlier samples of the three-tick window; the third is the
    // live synchroniser output on the decision tick. Pure data, no reset.
    logic              r_maj_a;
    logic              r_maj_b;
    logic [TICK_W-1:0] w_win_a;
    logic [TICK_W-1:0] w_win_b;

    assign w_win_a = (r_state == S_START) ? START_WIN_A : BIT_WIN_A;
    assign w_win_b = (r_state == S_START) ? START_WIN_B : BIT_WIN_B;

    always_ff @(posedge clk) begin
        if (w_tick) begin
            if (r_tick_cnt == w_win_a) begin
                r_maj_a <= w_rxd_s;
            end
            if (r_tick_cnt == w_win_b) begin
                r_maj_b <= w_rxd_s;
            end
        end
    end

    assign w_sample = (r_maj_a & r_maj_b) | (r_maj_a & w_rxd_s) | (r_maj_b & w_rxd_s);
`else
    assign w_sample = w_rxd_s;
`endif

    // ------------------------------------------------------------------------
    // FSM next-state / counter logic. Nothing moves without a qualified tick.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_tick_cnt_nxt = r_tick_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_armed_nxt    = r_armed;
        w_shift_en     = 1'b0;
        w_load         = 1'b0;

        if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    // armed follows the line while idle: it needs at least
                    // one high tick before a falling edge counts, so a line
                    // held low after a frame cannot start another one.
                    w_armed_nxt = w_rxd_s;
                    if (r_armed && !w_rxd_s) begin
                        w_state_nxt    = S_START;
                        w_tick_cnt_nxt = '0;
                    end
                end

                S_START: begin
                    if (r_tick_cnt == START_LAST) begin
                        if (w_sample) begin
                            // Line back high at mid start bit: glitch.
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt    = S_DATA;
                            w_tick_cnt_nxt = RELOAD;
                            w_bit_cnt_nxt  = '0;
                        end
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (r_tick_cnt == BIT_LAST) begin
                        w_shift_en     = 1'b1;
                        w_tick_cnt_nxt = RELOAD;
                        w_bit_cnt_nxt  = r_bit_cnt + 1'b1;
                        if (r_bit_cnt == LAST_BIT) begin
                            w_state_nxt = S_STOP;
                        end
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (r_tick_cnt == BIT_LAST) begin
                        w_load         = 1'b1;
                        w_state_nxt    = S_IDLE;
                        w_tick_cnt_nxt = '0;
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                    end
                end

                default: begin
                    w_state_nxt    = S_IDLE;
                    w_tick_cnt_nxt = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM state and counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_armed    <= 1'b0;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_armed    <= w_armed_nxt;
            r_tick_cnt <= w_tick_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
        end
    end

    // Right shift with the new sample entering at the MSB, so the first
    // (least significant) bit ends up in bit 0 after DATA_BITS shifts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
        end else if (w_shift_en) begin
            r_shift <= {w_sample, r_shift[DATA_BITS-1:1]};
        end
    end

    // ------------------------------------------------------------------------
    // Receive data register and status flags.
    // A load always wins over rd in the same cycle: rda stays set and the new
    // frame's framing error is recorded. The rd still acknowledges the old
    // byte, so it suppresses the overrun and clears the previously held flags.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_data     <= '0;
            r_rda         <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun_err <= 1'b0;
        end else if (w_load) begin
            r_rx_data     <= r_shift;
            r_rda         <= 1'b1;
            r_framing_err <= ~w_sample | (r_framing_err & ~bus.rd);
            r_overrun_err <= (r_rda | r_overrun_err) & ~bus.rd;
        end else if (bus.rd && r_rda) begin
            r_rda         <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun_err <= 1'b0;
        end
    end

    assign bus.rx_data     = r_rx_data;
    assign bus.rda         = r_rda;
    assign bus.framing_err = r_framing_err;
    assign bus.overrun_err = r_overrun_err;

endmodule
